alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Producer side of the ALU operand/control interface. Decodes one RV64I instruction per handshake into
//  ALUctl/ALUsrc/Immediate plus operands; presents them registered to the ALU (ID/EX boundary).
//  Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops an instruction.
// PARAMETERS
//  XLEN      64  operand/immediate width
//  DEPTH      2  skid entries (fixed at 2; other values unsupported)
// PORTS
//  i_Clk        in   1     clock, rising edge
//  i_Rst        in   1     reset, asynchronous, active-high
//  i_Flush      in   1     synchronous discard of all buffered entries
//  i_Valid      in   1     upstream instruction valid
//  o_Ready      out  1     upstream may transfer (registered)
//  i_Instr      in   32    instruction word
//  i_Rs1Data    in   XLEN  rs1 value, same cycle as i_Instr
//  i_Rs2Data    in   XLEN  rs2 value, same cycle as i_Instr
//  o_Valid      out  1     ALU bundle valid
//  i_Ready      in   1     ALU/EX consumes bundle
//  o_ALUctl     out  4     ALU operation
//  o_ALUsrc     out  1     1: ALU operand B = o_Immediate, 0: o_Rs2
//  o_Rs1        out  XLEN  operand A
//  o_Rs2        out  XLEN  operand B (register)
//  o_Immediate  out  XLEN  sign-extended immediate
//  o_Rd         out  5     destination register
//  o_RegWrite   out  1     write-back enable
//  o_Branch     out  1     branch; EX uses ALU zero/result with o_Funct3
//  o_Funct3     out  3     funct3 passthrough
//  o_Illegal    out  1     unsupported encoding
// BEHAVIOUR
//  - ALUctl: AND=0000 OR=0001 ADD=0010 XOR=0011 SLL=0100 SRL=0101 SUB=0110 SLT=0111 SLTU=1000 SRA=1001.
//  - Decode: OP(0x33) R-type, ALUsrc=0; OP-IMM(0x13) I-imm, ALUsrc=1, shamt=imm[5:0], imm[10] selects SRA.
//    LOAD(0x03)/STORE(0x23): ADD, ALUsrc=1, I-/S-imm, RegWrite only for LOAD.
//    BRANCH(0x63): BEQ/BNE->SUB, BLT/BGE->SLT, BLTU/BGEU->SLTU; ALUsrc=0, RegWrite=0, B-imm.
//    LUI(0x37): ADD, o_Rs1 forced 0, U-imm sign-extended from bit 31.
//    Other opcode, or bad funct7 on OP: o_Illegal=1, ALUctl=ADD, RegWrite=0.
//  - Rd==0 forces o_RegWrite=0.
//  - Transfer in on i_Valid&&o_Ready; transfer out on o_Valid&&i_Ready. Latency: 1 cycle from accept to o_Valid.
//  - Skid FSM. EMPTY: accept -> ONE.
//    ONE: accept&&!drain -> FULL; drain&&!accept -> EMPTY; both -> ONE (output reloads from input).
//    FULL: o_Ready=0; drain -> ONE (skid entry moves to output register).
//  - o_Ready = (state!=FULL), registered; never combinationally depends on i_Ready.
//  - Output bundle stays stable while o_Valid&&!i_Ready.
//  - i_Flush: next state EMPTY, o_Valid=0; a same-cycle accept is also discarded. Flush wins over all events.
//  - Reset (async, any state): state EMPTY, o_Valid=0, o_Ready=1; every data output 0, incl. o_ALUctl=0000 and o_Illegal=0.
// CONFIGURATION
//  ALU_ISSUE_WORD_OPS_EN defined:
//   - Decodes OP-32(0x3B) and OP-IMM-32(0x1B) (ADDW/SUBW/SLLW/SRLW/SRAW, *IW forms).
//   - Adds output o_Word (1 bit, reset 0) marking 32-bit ops; shamt=imm[4:0].
//   - EX sign-extends bit 31 of the result.
//  Undefined: no o_Word port; opcodes 0x1B/0x3B decode as illegal.
// STRUCTURE
//  - Shared include rtl/core/alu_defs.vh holds ALUctl codes, opcode constants and skid state encodings.
//    The ALU and this block both use it.
//  - Sub-module skid_buffer: WIDTH-parameterised 2-entry valid/ready register.
//    alu_issue_stage = combinational decoder feeding skid_buffer.
// TESTING
//  - ADDI x1,x0,7 (0x00700093), i_Ready=1 -> next cycle: o_Valid=1, ALUctl=0010, ALUsrc=1, Imm=7, Rd=1, RegWrite=1.
//  - SUB x3,x1,x2 (0x402081B3), Rs1=6, Rs2=5 -> ALUctl=0110, ALUsrc=0, o_Rs1=6, o_Rs2=5, Rd=3.
//  - SRAI x5,x6,3 (0x40335293) -> ALUctl=1001, Imm=3. BEQ x1,x2,0 (0x00208063) -> SUB, Branch=1, RegWrite=0.
//  - Back-pressure: hold i_Ready=0 and push 3 instrs -> o_Ready=0 after 2 accepted.
//    Release i_Ready -> exactly 2 bundles out, in order, unchanged.
//  - i_Flush while FULL with i_Valid=1 -> next cycle o_Valid=0, o_Ready=1; no bundle ever emitted.
//  - ADDW 0x003100BB -> macro on: ALUctl=0010, o_Word=1; macro off: o_Illegal=1, RegWrite=0.
//    Async i_Rst mid-FULL -> outputs 0 immediately.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - ALU control codes, opcodes, skid states and issue bundle layout
// Shared by the issue stage, its skid buffer and the ALU.
// Optional feature macro: ALU_ISSUE_WORD_OPS_EN (adds the word flag to the bundle).
package alu_issue_stage_pkg;

    localparam int XLEN = 64;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctl_e;

    localparam logic [6:0] OPC_OP         = 7'h33;
    localparam logic [6:0] OPC_OP_IMM     = 7'h13;
    localparam logic [6:0] OPC_LOAD       = 7'h03;
    localparam logic [6:0] OPC_STORE      = 7'h23;
    localparam logic [6:0] OPC_BRANCH     = 7'h63;
    localparam logic [6:0] OPC_LUI        = 7'h37;
    localparam logic [6:0] OPC_OP_32      = 7'h3B;
    localparam logic [6:0] OPC_OP_IMM_32  = 7'h1B;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [3:0]      alu_ctl;
        logic            alu_src;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            reg_write;
        logic            branch;
        logic [2:0]      funct3;
        logic            illegal;
`ifdef ALU_ISSUE_WORD_OPS_EN
        logic            word;
`endif
    } issue_bundle_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101; callers qualify it.
    function automatic logic [3:0] alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_stage_skid_buffer.sv
// rtl/alu_issue_stage_skid_buffer.sv - 2-entry valid/ready skid register
// Ports: i_Clk, i_Rst (async, active-high), i_Flush; upstream i_Valid/o_Ready/i_Data;
//        downstream o_Valid/i_Ready/o_Data. o_Ready is registered and independent of i_Ready.
module alu_issue_stage_skid_buffer
    import alu_issue_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Flush,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [WIDTH-1:0] i_Data,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_Data
);

    skid_state_e      state_q, state_d;
    logic             ready_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;
    logic             drain;

    assign accept = i_Valid && ready_q;
    assign drain  = (state_q != SKID_EMPTY) && i_Ready;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            // Registered copy of "next state is not FULL" keeps o_Ready off the i_Ready path.
            ready_q <= (state_d != SKID_FULL);
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_Flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: if (accept) state_d = SKID_ONE;
                SKID_ONE: begin
                    if (accept && !drain)      state_d = SKID_FULL;
                    else if (drain && !accept) state_d = SKID_EMPTY;
                end
                SKID_FULL:  if (drain) state_d = SKID_ONE;
                default:    state_d = SKID_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (!i_Flush) begin
            case (state_q)
                SKID_EMPTY: if (accept) out_d = i_Data;
                SKID_ONE: begin
                    if (accept && drain) out_d  = i_Data;
                    else if (accept)     skid_d = i_Data;
                end
                SKID_FULL:  if (drain) out_d = skid_q;
                default: ;
            endcase
        end
    end

    assign o_Valid = (state_q != SKID_EMPTY);
    assign o_Ready = ready_q;
    assign o_Data  = out_q;

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV64I decoder feeding a registered ALU issue skid buffer
// Ports: i_Clk, i_Rst (async, active-high), i_Flush; upstream i_Valid/o_Ready with
//        i_Instr, i_Rs1Data, i_Rs2Data; downstream o_Valid/i_Ready with o_ALUctl, o_ALUsrc,
//        o_Rs1, o_Rs2, o_Immediate, o_Rd, o_RegWrite, o_Branch, o_Funct3, o_Illegal.
// Macro ALU_ISSUE_WORD_OPS_EN: decodes OP-32/OP-IMM-32 and adds o_Word.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic            i_Clk,
    input  logic            i_Rst,
    input  logic            i_Flush,
    input  logic            i_Valid,
    output logic            o_Ready,
    input  logic [31:0]     i_Instr,
    input  logic [XLEN-1:0] i_Rs1Data,
    input  logic [XLEN-1:0] i_Rs2Data,
    output logic            o_Valid,
    input  logic            i_Ready,
    output logic [3:0]      o_ALUctl,
    output logic            o_ALUsrc,
    output logic [XLEN-1:0] o_Rs1,
    output logic [XLEN-1:0] o_Rs2,
    output logic [XLEN-1:0] o_Immediate,
    output logic [4:0]      o_Rd,
    output logic            o_RegWrite,
    output logic            o_Branch,
    output logic [2:0]      o_Funct3,
    output logic            o_Illegal
`ifdef ALU_ISSUE_WORD_OPS_EN
    ,
    output logic            o_Word
`endif
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u;
    logic            r_funct7_ok;
    issue_bundle_t   dec;
    issue_bundle_t   out_bundle;

    assign opcode = i_Instr[6:0];
    assign rd     = i_Instr[11:7];
    assign funct3 = i_Instr[14:12];
    assign funct7 = i_Instr[31:25];

    assign imm_i = {{(XLEN-12){i_Instr[31]}}, i_Instr[31:20]};
    assign imm_s = {{(XLEN-12){i_Instr[31]}}, i_Instr[31:25], i_Instr[11:7]};
    assign imm_b = {{(XLEN-13){i_Instr[31]}}, i_Instr[31], i_Instr[7], i_Instr[30:25], i_Instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){i_Instr[31]}}, i_Instr[31:12], 12'b0};

    // funct7=0100000 is only meaningful for SUB and SRA.
    assign r_funct7_ok = (funct7 == 7'h00) ||
                         ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    always_comb begin
        dec         = '0;
        dec.rs1     = i_Rs1Data;
        dec.rs2     = i_Rs2Data;
        dec.rd      = rd;
        dec.funct3  = funct3;
        dec.alu_ctl = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                dec.reg_write = 1'b1;
                dec.alu_ctl   = alu_op_from_funct3(funct3, i_Instr[30]);
                dec.illegal   = !r_funct7_ok;
            end
            OPC_OP_IMM: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                // ADDI with imm bit 10 set is still ADD; only the right shift uses it.
                dec.alu_ctl   = alu_op_from_funct3(funct3, (funct3 == 3'b101) && i_Instr[30]);
                if ((funct3 == 3'b001) || (funct3 == 3'b101))
                    dec.imm = {{(XLEN-6){1'b0}}, i_Instr[25:20]};
                else
                    dec.imm = imm_i;
            end
            OPC_LOAD: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = imm_i;
            end
            OPC_STORE: begin
                dec.alu_src = 1'b1;
                dec.imm     = imm_s;
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                dec.imm    = imm_b;
                case (funct3[2:1])
                    2'b10:   dec.alu_ctl = ALU_SLT;
                    2'b11:   dec.alu_ctl = ALU_SLTU;
                    default: dec.alu_ctl = ALU_SUB;
                endcase
            end
            OPC_LUI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.rs1       = '0;
                dec.imm       = imm_u;
            end
`ifdef ALU_ISSUE_WORD_OPS_EN
            OPC_OP_32: begin
                dec.word      = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_ctl   = alu_op_from_funct3(funct3, i_Instr[30]);
                dec.illegal   = !(r_funct7_ok && ((funct3 == 3'b000) || (funct3 == 3'b001) ||
                                                  (funct3 == 3'b101)));
            end
            OPC_OP_IMM_32: begin
                dec.word      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_ctl   = alu_op_from_funct3(funct3, (funct3 == 3'b101) && i_Instr[30]);
                if (funct3 == 3'b000) begin
                    dec.imm = imm_i;
                end else begin
                    dec.imm     = {{(XLEN-5){1'b0}}, i_Instr[24:20]};
                    dec.illegal = !(r_funct7_ok && ((funct3 == 3'b001) || (funct3 == 3'b101)));
                end
            end
`endif
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.alu_ctl   = ALU_ADD;
            dec.reg_write = 1'b0;
            dec.branch    = 1'b0;
        end
        if (rd == 5'd0) dec.reg_write = 1'b0;
    end

    alu_issue_stage_skid_buffer #(
        .WIDTH($bits(issue_bundle_t))
    ) u_skid (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Flush(i_Flush),
        .i_Valid(i_Valid),
        .o_Ready(o_Ready),
        .i_Data (dec),
        .o_Valid(o_Valid),
        .i_Ready(i_Ready),
        .o_Data (out_bundle)
    );

    assign o_ALUctl    = out_bundle.alu_ctl;
    assign o_ALUsrc    = out_bundle.alu_src;
    assign o_Rs1       = out_bundle.rs1;
    assign o_Rs2       = out_bundle.rs2;
    assign o_Immediate = out_bundle.imm;
    assign o_Rd        = out_bundle.rd;
    assign o_RegWrite  = out_bundle.reg_write;
    assign o_Branch    = out_bundle.branch;
    assign o_Funct3    = out_bundle.funct3;
    assign o_Illegal   = out_bundle.illegal;
`ifdef ALU_ISSUE_WORD_OPS_EN
    assign o_Word      = out_bundle.word;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] instr;
    logic [63:0] rs1_data, rs2_data;
    logic        o_ready, o_valid, o_alusrc, o_regwrite, o_branch, o_illegal;
    logic [3:0]  o_aluctl;
    logic [63:0] o_rs1, o_rs2, o_imm;
    logic [4:0]  o_rd;
    logic [2:0]  o_funct3;
`ifdef ALU_ISSUE_WORD_OPS_EN
    logic        o_word;
`endif

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .i_Clk(clk), .i_Rst(rst), .i_Flush(flush),
        .i_Valid(in_valid), .o_Ready(o_ready),
        .i_Instr(instr), .i_Rs1Data(rs1_data), .i_Rs2Data(rs2_data),
        .o_Valid(o_valid), .i_Ready(in_ready),
        .o_ALUctl(o_aluctl), .o_ALUsrc(o_alusrc), .o_Rs1(o_rs1), .o_Rs2(o_rs2),
        .o_Immediate(o_imm), .o_Rd(o_rd), .o_RegWrite(o_regwrite), .o_Branch(o_branch),
        .o_Funct3(o_funct3), .o_Illegal(o_illegal)
`ifdef ALU_ISSUE_WORD_OPS_EN
        , .o_Word(o_word)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  ctl;
        logic        src;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic [2:0]  f3;
        logic        ill;
        logic        wd;
        logic        rs1z;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [63:0] rs1;
        logic [63:0] rs2;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t cur;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   emitted = 0;

    function automatic vec_t mk(logic [31:0] i, logic [3:0] c, logic s, logic [63:0] im, logic [4:0] r,
                                logic w, logic b, logic [2:0] f, logic il, logic wd, logic z);
        vec_t v;
        v.instr = i; v.ctl = c; v.src = s; v.imm = im; v.rd = r; v.rw = w;
        v.br = b; v.f3 = f; v.ill = il; v.wd = wd; v.rs1z = z;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic compare(input exp_t e, input string tag);
        check({tag, ".ctl"},   64'(o_aluctl),   64'(e.v.ctl));
        check({tag, ".src"},   64'(o_alusrc),   64'(e.v.src));
        check({tag, ".imm"},   o_imm,           e.v.imm);
        check({tag, ".rd"},    64'(o_rd),       64'(e.v.rd));
        check({tag, ".rw"},    64'(o_regwrite), 64'(e.v.rw));
        check({tag, ".br"},    64'(o_branch),   64'(e.v.br));
        check({tag, ".f3"},    64'(o_funct3),   64'(e.v.f3));
        check({tag, ".ill"},   64'(o_illegal),  64'(e.v.ill));
        check({tag, ".rs1"},   o_rs1,           e.v.rs1z ? 64'd0 : e.rs1);
        check({tag, ".rs2"},   o_rs2,           e.rs2);
`ifdef ALU_ISSUE_WORD_OPS_EN
        check({tag, ".word"},  64'(o_word),     64'(e.v.wd));
`endif
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        instr    = v.instr;
        rs1_data = {$urandom(), $urandom()};
        rs2_data = {$urandom(), $urandom()};
        cur.v    = v;
        cur.rs1  = rs1_data;
        cur.rs2  = rs2_data;
    endtask

    // Called #1 after a rising edge with inputs settled: scores this cycle's handshakes, then advances.
    task automatic step(output bit acc);
        bit drn;
        acc = in_valid && o_ready;
        drn = o_valid && in_ready;
        if (drn) begin
            emitted++;
            if (sb.size() == 0) check("unexpected_bundle", 64'd1, 64'd0);
            else compare(sb.pop_front(), $sformatf("out%0d", emitted));
        end else if (o_valid && sb.size() > 0) begin
            compare(sb[0], "stall");
        end
        if (flush) sb.delete();
        else if (acc) sb.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all(input string tag);
        bit a;
        int n = 0;
        in_valid = 1'b0;
        in_ready = 1'b1;
        while (o_valid && n < 20) begin
            step(a);
            n++;
        end
        check({tag, ".drain_done"}, 64'(o_valid), 64'd0);
        check({tag, ".sb_empty"},   64'(sb.size()), 64'd0);
    endtask

    task automatic fill_full(input int base, input string tag);
        bit a;
        int n = 0;
        in_ready = 1'b0;
        drive(vecs[base]);
        for (int c = 0; c < 6 && n < 2; c++) begin
            step(a);
            if (a) begin
                n++;
                drive(vecs[base + 1]);
            end
        end
        check({tag, ".accepted"}, 64'(n), 64'd2);
    endtask

    initial begin
        bit acc;
        int guard;
        int acc_cnt;
        int idx;

        vecs.push_back(mk(32'h00700093, 4'h2, 1, 64'd7, 5'd1, 1, 0, 3'd0, 0, 0, 0));        // ADDI x1,x0,7
        vecs.push_back(mk(32'h402081B3, 4'h6, 0, 64'd0, 5'd3, 1, 0, 3'd0, 0, 0, 0));        // SUB x3,x1,x2
        vecs.push_back(mk(32'h40335293, 4'h9, 1, 64'd3, 5'd5, 1, 0, 3'd5, 0, 0, 0));        // SRAI x5,x6,3
        vecs.push_back(mk(32'h00208063, 4'h6, 0, 64'd0, 5'd0, 0, 1, 3'd0, 0, 0, 0));        // BEQ x1,x2,0
        vecs.push_back(mk(32'h80000537, 4'h2, 1, 64'hFFFFFFFF80000000, 5'd10, 1, 0, 3'd0, 0, 0, 1)); // LUI
        vecs.push_back(mk(32'hFFC12203, 4'h2, 1, 64'hFFFFFFFFFFFFFFFC, 5'd4, 1, 0, 3'd2, 0, 0, 0));  // LW -4
        vecs.push_back(mk(32'h02513023, 4'h2, 1, 64'd32, 5'd0, 0, 0, 3'd3, 0, 0, 0));       // SD x5,32(x2)
        vecs.push_back(mk(32'h8020E063, 4'h8, 0, 64'hFFFFFFFFFFFFF000, 5'd0, 0, 1, 3'd6, 0, 0, 0));  // BLTU -4096
        vecs.push_back(mk(32'h009423B3, 4'h7, 0, 64'd0, 5'd7, 1, 0, 3'd2, 0, 0, 0));        // SLT x7,x8,x9
        vecs.push_back(mk(32'h022081B3, 4'h2, 0, 64'd0, 5'd3, 0, 0, 3'd0, 1, 0, 0));        // MUL: bad funct7
`ifdef ALU_ISSUE_WORD_OPS_EN
        vecs.push_back(mk(32'h003100BB, 4'h2, 0, 64'd0, 5'd1, 1, 0, 3'd0, 0, 1, 0));        // ADDW
`else
        vecs.push_back(mk(32'h003100BB, 4'h2, 0, 64'd0, 5'd1, 0, 0, 3'd0, 1, 0, 0));        // ADDW illegal
`endif
        vecs.push_back(mk(32'h00208033, 4'h2, 0, 64'd0, 5'd0, 0, 0, 3'd0, 0, 0, 0));        // ADD x0: no write
        vecs.push_back(mk(32'h003150B3, 4'h5, 0, 64'd0, 5'd1, 1, 0, 3'd5, 0, 0, 0));        // SRL x1,x2,x3
        vecs.push_back(mk(32'hFFF16113, 4'h1, 1, 64'hFFFFFFFFFFFFFFFF, 5'd2, 1, 0, 3'd6, 0, 0, 0)); // ORI -1
        vecs.push_back(mk(32'h0000007F, 4'h2, 0, 64'd0, 5'd0, 0, 0, 3'd0, 1, 0, 0));        // bad opcode

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
        instr = '0; rs1_data = '0; rs2_data = '0;
        #12;
        check("rst.valid",   64'(o_valid),   64'd0);
        check("rst.ready",   64'(o_ready),   64'd1);
        check("rst.ctl",     64'(o_aluctl),  64'd0);
        check("rst.illegal", 64'(o_illegal), 64'd0);
        check("rst.imm",     o_imm,          64'd0);
        check("rst.rd",      64'(o_rd),      64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Streaming table run, downstream always ready.
        in_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            guard = 0;
            acc = 1'b0;
            while (!acc && guard < 10) begin
                step(acc);
                guard++;
            end
            if (!acc) check("table.accept_timeout", 64'd0, 64'd1);
            if (i == 0) check("latency.valid", 64'(o_valid), 64'd1);
        end
        drain_all("table");

        // Back-pressure: three offered, only two fit.
        in_ready = 1'b0;
        acc_cnt = 0;
        idx = 0;
        drive(vecs[0]);
        for (int c = 0; c < 5; c++) begin
            step(acc);
            if (acc) begin
                acc_cnt++;
                idx++;
                if (idx < 3) drive(vecs[idx]);
                else in_valid = 1'b0;
            end
        end
        check("bp.accepted", 64'(acc_cnt), 64'd2);
        check("bp.ready_low", 64'(o_ready), 64'd0);
        emitted = 0;
        drain_all("bp");
        check("bp.emitted", 64'(emitted), 64'd2);
        check("bp.ready_back", 64'(o_ready), 64'd1);

        // Flush while FULL with a pending input.
        fill_full(3, "flush_full");
        drive(vecs[5]);
        flush = 1'b1;
        step(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_full.valid", 64'(o_valid), 64'd0);
        check("flush_full.ready", 64'(o_ready), 64'd1);
        emitted = 0;
        in_ready = 1'b1;
        for (int c = 0; c < 4; c++) step(acc);
        check("flush_full.emitted", 64'(emitted), 64'd0);

        // Flush in ONE with a same-cycle accept: both are discarded.
        in_ready = 1'b0;
        drive(vecs[6]);
        step(acc);
        drive(vecs[7]);
        flush = 1'b1;
        step(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_one.valid", 64'(o_valid), 64'd0);
        emitted = 0;
        in_ready = 1'b1;
        for (int c = 0; c < 3; c++) step(acc);
        check("flush_one.emitted", 64'(emitted), 64'd0);

        // Asynchronous reset in the middle of a cycle while FULL.
        fill_full(8, "arst_fill");
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("arst.valid", 64'(o_valid),  64'd0);
        check("arst.ready", 64'(o_ready),  64'd1);
        check("arst.ctl",   64'(o_aluctl), 64'd0);
        check("arst.imm",   o_imm,         64'd0);
        check("arst.rs1",   o_rs1,         64'd0);
        check("arst.rd",    64'(o_rd),     64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;

        // Recovery after reset.
        in_ready = 1'b1;
        drive(vecs[2]);
        step(acc);
        check("recover.accept", 64'(acc), 64'd1);
        emitted = 0;
        drain_all("recover");
        check("recover.emitted", 64'(emitted), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
